// File: rtl/fetch_address_gen.sv
// Program-counter / fetch-request generator.
// Holds the PC, issues one cache query per cycle (tag/index/offset split of
// the PC) and steps the PC by 4. It rewinds to a missed address and replays it
// after the refill. It also loads redirect targets and holds the PC on
// downstream stalls.
module fetch_address_gen #(
  parameter int          offsetSize  = 5,
  parameter int          indexSize   = 8,
  parameter int          tagSize     = 64 - (offsetSize + indexSize),
  parameter logic [63:0] resetVector = 64'h0
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [63:0]           redirectAddr_i,
  input  logic                  isCacheMiss_i,
  input  logic [tagSize-1:0]    missTag_i,
  input  logic [indexSize-1:0]  missIndex_i,
  input  logic [offsetSize-1:0] missOffset_i,
  input  logic                  cacheUpdateEnable_i,
  output logic [tagSize-1:0]    tag_o,
  output logic [indexSize-1:0]  index_o,
  output logic [offsetSize-1:0] offset_o,
  output logic                  enable_o,
  output logic                  squash_o,
  output logic [63:0]           pc_o,
  output logic [31:0]           missCount_o
);

  localparam logic [1:0] FETCH     = 2'd0;
  localparam logic [1:0] MISS_WAIT = 2'd1;
  localparam logic [1:0] SETTLE    = 2'd2;

  // Instructions are word aligned, so the low two PC bits are always zero.
  localparam logic [63:0] ALIGN_MASK = ~64'h3;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_q, req_d;
  logic        enable_q, enable_d;
  logic        squash_q, squash_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Next-state logic: redirect beats everything, then miss, then stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    enable_d     = 1'b0;
    squash_d     = 1'b0;
    miss_count_d = miss_count_q;

    if (redirect_i) begin
      // Any refill still in flight is simply dropped; the cache absorbs it.
      pc_d     = redirectAddr_i & ALIGN_MASK;
      state_d  = FETCH;
      squash_d = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (isCacheMiss_i) begin
            pc_d     = {missTag_i, missIndex_i, missOffset_i};
            state_d  = MISS_WAIT;
            squash_d = 1'b1;
            if (miss_count_q != 32'hFFFF_FFFF) begin
              miss_count_d = miss_count_q + 32'd1;
            end
          end else if (!stall_i) begin
            req_d    = pc_q;
            enable_d = 1'b1;
            pc_d     = pc_q + 64'd4;
          end
        end
        MISS_WAIT: begin
          if (cacheUpdateEnable_i) begin
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          // One idle cycle so the hit/miss stage can drop its miss flag.
          state_d = FETCH;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State registers with immediate (asynchronous) reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= FETCH;
      pc_q         <= resetVector & ALIGN_MASK;
      req_q        <= 64'h0;
      enable_q     <= 1'b0;
      squash_q     <= 1'b0;
      miss_count_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      enable_q     <= enable_d;
      squash_q     <= squash_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign tag_o       = req_q[63 -: tagSize];
  assign index_o     = req_q[offsetSize +: indexSize];
  assign offset_o    = req_q[offsetSize-1:0];
  assign enable_o    = enable_q;
  assign squash_o    = squash_q;
  assign pc_o        = pc_q;
  assign missCount_o = miss_count_q;

endmodule

// File: tb/tb_fetch_address_gen.sv
// Directed testbench for fetch_address_gen. Two instances share all inputs.
// dut_a starts at 0x1000 and dut_b starts just below the 64-bit wrap point.
module tb_fetch_address_gen;

  localparam int OFS = 5;
  localparam int IDX = 8;
  localparam int TAG = 64 - (OFS + IDX);

  logic           clk = 1'b0;
  logic           rst;
  logic           stall, redirect, miss, cue;
  logic [63:0]    redirect_addr;
  logic [63:0]    miss_addr;

  logic [TAG-1:0] a_tag, b_tag;
  logic [IDX-1:0] a_index, b_index;
  logic [OFS-1:0] a_offset, b_offset;
  logic           a_en, b_en, a_sq, b_sq;
  logic [63:0]    a_pc, b_pc;
  logic [31:0]    a_mc, b_mc;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fetch_address_gen #(.offsetSize(OFS), .indexSize(IDX), .tagSize(TAG),
                      .resetVector(64'h1000)) dut_a (
    .clock_i(clk), .reset_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirectAddr_i(redirect_addr), .isCacheMiss_i(miss),
    .missTag_i(miss_addr[63:13]), .missIndex_i(miss_addr[12:5]),
    .missOffset_i(miss_addr[4:0]), .cacheUpdateEnable_i(cue),
    .tag_o(a_tag), .index_o(a_index), .offset_o(a_offset), .enable_o(a_en),
    .squash_o(a_sq), .pc_o(a_pc), .missCount_o(a_mc));

  fetch_address_gen #(.offsetSize(OFS), .indexSize(IDX), .tagSize(TAG),
                      .resetVector(64'hFFFF_FFFF_FFFF_FFF8)) dut_b (
    .clock_i(clk), .reset_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirectAddr_i(redirect_addr), .isCacheMiss_i(miss),
    .missTag_i(miss_addr[63:13]), .missIndex_i(miss_addr[12:5]),
    .missOffset_i(miss_addr[4:0]), .cacheUpdateEnable_i(cue),
    .tag_o(b_tag), .index_o(b_index), .offset_o(b_offset), .enable_o(b_en),
    .squash_o(b_sq), .pc_o(b_pc), .missCount_o(b_mc));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a request on dut_a: enable high, address, squash low, next pc.
  task automatic req_a(input string tag, input logic [63:0] addr, input logic [63:0] pc);
    check({tag, ".en"}, {63'h0, a_en}, 64'h1);
    check({tag, ".addr"}, {a_tag, a_index, a_offset}, addr);
    check({tag, ".sq"}, {63'h0, a_sq}, 64'h0);
    check({tag, ".pc"}, a_pc, pc);
    $display("req  %-8s addr=0x%016h pc=0x%016h en=%0b", tag, {a_tag, a_index, a_offset}, a_pc, a_en);
  endtask

  // Checks that dut_a is idle this cycle, with the expected squash, pc and count.
  task automatic idle_a(input string tag, input logic sq, input logic [63:0] pc, input logic [31:0] mc);
    check({tag, ".en"}, {63'h0, a_en}, 64'h0);
    check({tag, ".sq"}, {63'h0, a_sq}, {63'h0, sq});
    check({tag, ".pc"}, a_pc, pc);
    check({tag, ".mc"}, {32'h0, a_mc}, {32'h0, mc});
    $display("idle %-8s pc=0x%016h sq=%0b mc=%0d", tag, a_pc, a_sq, a_mc);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; miss = 1'b0; cue = 1'b0;
    redirect_addr = 64'h0; miss_addr = 64'h0;

    // Reset state, sampled during reset.
    #10;
    idle_a("rst", 1'b0, 64'h1000, 32'd0);
    check("rst.addr", {a_tag, a_index, a_offset}, 64'h0);
    check("rst.b_pc", b_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    #2 rst = 1'b0;

    // T1: four requests from the reset vector.
    step(); req_a("t1.0", 64'h1000, 64'h1004);
    step(); req_a("t1.1", 64'h1004, 64'h1008);
    step(); req_a("t1.2", 64'h1008, 64'h100C);
    step(); req_a("t1.3", 64'h100C, 64'h1010);

    // T2: three stalled cycles, then resume with no skip or duplicate.
    stall = 1'b1;
    step(); idle_a("t2.s0", 1'b0, 64'h1010, 32'd0);
    step(); idle_a("t2.s1", 1'b0, 64'h1010, 32'd0);
    step(); idle_a("t2.s2", 1'b0, 64'h1010, 32'd0);
    stall = 1'b0;
    step(); req_a("t2.r0", 64'h1010, 64'h1014);
    step(); req_a("t2.r1", 64'h1014, 64'h1018);

    // T3: a miss at 0x1008 is held, then refilled after 10 cycles.
    miss = 1'b1; miss_addr = 64'h1008;
    step(); idle_a("t3.cap", 1'b1, 64'h1008, 32'd1);
    for (int i = 0; i < 9; i++) begin
      step(); idle_a("t3.wait", 1'b0, 64'h1008, 32'd1);
    end
    cue = 1'b1;
    step(); idle_a("t3.refil", 1'b0, 64'h1008, 32'd1);
    cue = 1'b0;
    step(); idle_a("t3.settl", 1'b0, 64'h1008, 32'd1);
    miss = 1'b0;
    step(); req_a("t3.replay", 64'h1008, 64'h100C);
    check("t3.mc", {32'h0, a_mc}, 64'd1);

    // T4: a redirect in the same cycle as a miss; the redirect wins.
    redirect = 1'b1; redirect_addr = 64'h2003; miss = 1'b1; miss_addr = 64'h5000;
    step(); idle_a("t4.redir", 1'b1, 64'h2000, 32'd1);
    redirect = 1'b0; miss = 1'b0;
    step(); req_a("t4.next", 64'h2000, 64'h2004);

    // A miss and a stall in the same FETCH cycle; the miss wins.
    miss = 1'b1; stall = 1'b1; miss_addr = 64'h3000;
    step(); idle_a("ms.cap", 1'b1, 64'h3000, 32'd2);
    stall = 1'b0;

    // T6: reset while in MISS_WAIT clears the outputs with no clock edge.
    #3 rst = 1'b1;
    #1;
    idle_a("t6.rst", 1'b0, 64'h1000, 32'd0);
    check("t6.addr", {a_tag, a_index, a_offset}, 64'h0);
    cue = 1'b1; miss = 1'b0;
    #1 rst = 1'b0;
    // The refill pulse seen on the first edge after reset is ignored.
    step(); req_a("t6.r0", 64'h1000, 64'h1004);
    cue = 1'b0;

    // T5: dut_b walks across the 64-bit wrap (it restarted with the same reset).
    check("t5.0.en", {63'h0, b_en}, 64'h1);
    check("t5.0.addr", {b_tag, b_index, b_offset}, 64'hFFFF_FFFF_FFFF_FFF8);
    $display("req  t5.0     addr=0x%016h pc=0x%016h", {b_tag, b_index, b_offset}, b_pc);
    step(); req_a("t6.r1", 64'h1004, 64'h1008);
    check("t5.1.addr", {b_tag, b_index, b_offset}, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t5.1.pc", b_pc, 64'h0);
    $display("req  t5.1     addr=0x%016h pc=0x%016h", {b_tag, b_index, b_offset}, b_pc);
    step();
    check("t5.2.en", {63'h0, b_en}, 64'h1);
    check("t5.2.addr", {b_tag, b_index, b_offset}, 64'h0);
    check("t5.2.pc", b_pc, 64'h4);
    $display("req  t5.2     addr=0x%016h pc=0x%016h", {b_tag, b_index, b_offset}, b_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
